// File: rtl/medfilt_win_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : medfilt_win_ctrl
// Purpose  : Frame sequencer for the 3x3 median-filter datapath. Accepts the
//            pixel stream, tracks position, drives the shared line-buffer /
//            window shift enable, inserts one pad shift per row and a flush
//            row per frame, and tags each completed window with its centre
//            coordinate and border flags.
// Options  : MEDF_FRAME_CNT_EN - adds a 16-bit count of completed frames.
// Revision : 1.0 - initial release
// ============================================================================
module medfilt_win_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 512,
  localparam int CW = $clog2(IMG_W),
  localparam int RW = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          s_sof,
  input  logic          s_eol,
  output logic          lb_shift,
  output logic          lb_pad,
  output logic          win_valid,
  output logic [CW-1:0] win_col,
  output logic [RW-1:0] win_row,
  output logic [3:0]    border,
  output logic          frame_done,
  output logic          err_sync
`ifdef MEDF_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  // Flush counter runs 0..IMG_W (IMG_W virtual pixels plus the row pad)
  localparam int FW = $clog2(IMG_W + 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(IMG_W);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_EOL_PAD = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [FW-1:0] fcnt;

  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          win_hit;
  logic [CW-1:0] win_c;
  logic [RW-1:0] win_r;

  assign accept   = s_valid & s_ready;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);

  // Shift enable must coincide with the pixel on the data bus, so it is decoded
  // combinationally; also works out which window (if any) this shift completes.
  always_comb begin
    lb_shift = 1'b0;
    lb_pad   = 1'b0;
    win_hit  = 1'b0;
    win_c    = '0;
    win_r    = '0;
    case (state)
      ST_IDLE: begin
        lb_shift = accept & s_sof;
      end
      ST_RUN: begin
        if (accept) begin
          if (s_sof) begin
            // Restart at (0,0): shifted, but completes no window
            lb_shift = 1'b1;
          end else if (s_eol == col_last) begin
            lb_shift = 1'b1;
            if ((row != '0) && (col != '0)) begin
              win_hit = 1'b1;
              win_r   = row - RW'(1);
              win_c   = col - CW'(1);
            end
          end
        end
      end
      ST_EOL_PAD: begin
        lb_shift = 1'b1;
        lb_pad   = 1'b1;
        if (row != '0) begin
          win_hit = 1'b1;
          win_r   = row - RW'(1);
          win_c   = COL_LAST;
        end
      end
      ST_FLUSH: begin
        lb_shift = 1'b1;
        lb_pad   = 1'b1;
        if (fcnt != '0) begin
          win_hit = 1'b1;
          win_r   = ROW_LAST;
          win_c   = CW'(fcnt - FW'(1));
        end
      end
      default: begin
        lb_shift = 1'b0;
      end
    endcase
  end

  // Frame state machine with registered handshake, window tag and status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      s_ready    <= 1'b0;
      col        <= '0;
      row        <= '0;
      fcnt       <= '0;
      win_valid  <= 1'b0;
      win_col    <= '0;
      win_row    <= '0;
      border     <= '0;
      frame_done <= 1'b0;
      err_sync   <= 1'b0;
    end else begin
      win_valid  <= win_hit;
      if (win_hit) begin
        win_col <= win_c;
        win_row <= win_r;
        border  <= {win_r == '0, win_r == ROW_LAST, win_c == '0, win_c == COL_LAST};
      end
      frame_done <= (state == ST_DONE);

      case (state)
        ST_IDLE: begin
          s_ready <= 1'b1;
          if (accept && s_sof) begin
            col   <= CW'(1);
            row   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          s_ready <= 1'b1;
          if (accept) begin
            if (s_sof) begin
              err_sync <= 1'b1;
              col      <= CW'(1);
              row      <= '0;
            end else if (s_eol != col_last) begin
              // Misplaced or missing end-of-line: abandon the frame
              err_sync <= 1'b1;
              state    <= ST_IDLE;
            end else if (col_last) begin
              s_ready <= 1'b0;
              state   <= ST_EOL_PAD;
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        ST_EOL_PAD: begin
          col <= '0;
          if (row_last) begin
            s_ready <= 1'b0;
            fcnt    <= '0;
            state   <= ST_FLUSH;
          end else begin
            s_ready <= 1'b1;
            row     <= row + RW'(1);
            state   <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          s_ready <= 1'b0;
          if (fcnt == FCNT_LAST) begin
            state <= ST_DONE;
          end else begin
            fcnt <= fcnt + FW'(1);
          end
        end
        ST_DONE: begin
          s_ready <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          s_ready <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MEDF_FRAME_CNT_EN
  // Completed-frame counter; only frames that reach DONE are counted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (state == ST_DONE) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_medfilt_win_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_medfilt_win_ctrl
// Purpose  : Self-checking bench for medfilt_win_ctrl (IMG_W=4, IMG_H=3).
//            Expected windows are queued when a frame is driven and compared
//            in order as win_valid pulses arrive.
// Options  : MEDF_FRAME_CNT_EN - also exercises frame_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module tb_medfilt_win_ctrl;

  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_sof = 1'b0;
  logic          s_eol = 1'b0;
  logic          s_ready;
  logic          lb_shift;
  logic          lb_pad;
  logic          win_valid;
  logic [CW-1:0] win_col;
  logic [RW-1:0] win_row;
  logic [3:0]    border;
  logic          frame_done;
  logic          err_sync;
`ifdef MEDF_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  medfilt_win_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_sof      (s_sof),
    .s_eol      (s_eol),
    .lb_shift   (lb_shift),
    .lb_pad     (lb_pad),
    .win_valid  (win_valid),
    .win_col    (win_col),
    .win_row    (win_row),
    .border     (border),
    .frame_done (frame_done),
    .err_sync   (err_sync)
`ifdef MEDF_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    int c;
  } win_t;

  win_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   shift_cnt = 0;
  int   pad_cnt = 0;
  int   stall_cnt = 0;
  int   done_cnt = 0;
  logic prev_final = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_border(input int r, input int c);
    return {r == 0, r == IMG_H - 1, c == 0, c == IMG_W - 1};
  endfunction

  // Monitor: samples mid-cycle, counts shifts/pads and scores windows
  always begin
    @(negedge clk);
    #2;
    if (lb_shift) shift_cnt++;
    if (lb_pad) pad_cnt++;
    if (lb_pad && !s_ready) stall_cnt++;
    if (frame_done) done_cnt++;
    if (frame_done || prev_final) check_eq("done_timing", {31'd0, frame_done}, {31'd0, prev_final});
    prev_final = win_valid && (int'(win_row) == IMG_H - 1) && (int'(win_col) == IMG_W - 1);
    if (win_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("win_unexpected", {31'd0, win_valid}, 32'd0);
      end else begin
        win_t e;
        e = exp_q.pop_front();
        check_eq("win_row", 32'(win_row), 32'(e.r));
        check_eq("win_col", 32'(win_col), 32'(e.c));
        check_eq("border", 32'(border), 32'(exp_border(e.r, e.c)));
        case ({e.r[7:0], e.c[7:0]})
          16'h0000: check_eq("border_00", 32'(border), 32'h0000000a);
          16'h0203: check_eq("border_23", 32'(border), 32'h00000005);
          16'h0101: check_eq("border_11", 32'(border), 32'h00000000);
          16'h0103: check_eq("border_13", 32'(border), 32'h00000001);
          default: ;
        endcase
      end
    end
  end

  task automatic push_windows(input int first_row, input int last_row);
    for (int r = first_row; r <= last_row; r++)
      for (int c = 0; c < IMG_W; c++) begin
        win_t w;
        w.r = r;
        w.c = c;
        exp_q.push_back(w);
      end
  endtask

  task automatic send_px(input logic sof, input logic eol);
    int n = 0;
    @(negedge clk);
    #1;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!s_ready) check_eq("ready_timeout", {31'd0, s_ready}, 32'd1);
    s_valid = 1'b1;
    s_sof   = sof;
    s_eol   = eol;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
  endtask

  task automatic send_frame(input int gap, input int skip);
    for (int i = skip; i < IMG_W * IMG_H; i++) begin
      send_px(i == 0, (i % IMG_W) == IMG_W - 1);
      repeat (gap) @(posedge clk);
    end
  endtask

  task automatic wait_done(input string tag);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check_eq(tag, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clean_frame(input string tag, input int gap);
    int s0 = shift_cnt;
    int p0 = pad_cnt;
    int t0 = stall_cnt;
    push_windows(0, IMG_H - 1);
    send_frame(gap, 0);
    wait_done({tag, "_done"});
    check_eq({tag, "_shifts"}, 32'(shift_cnt - s0), 32'd20);
    check_eq({tag, "_pads"}, 32'(pad_cnt - p0), 32'd8);
    check_eq({tag, "_pad_stall"}, 32'(stall_cnt - t0), 32'd8);
    check_eq({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int d0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outputs",
             {18'd0, s_ready, lb_shift, lb_pad, win_valid, frame_done, err_sync, border, win_col, win_row},
             32'd0);
    rst_n = 1'b1;

    // Clean frame, continuous valid, then alternating valid
    clean_frame("cont", 0);
    check_eq("cont_err", {31'd0, err_sync}, 32'd0);
    clean_frame("gap", 1);

    // End-of-line at column 2 of row 1
    exp_q.push_back('{0, 0});
    for (int c = 0; c < IMG_W; c++) send_px(c == 0, c == IMG_W - 1);
    send_px(1'b0, 1'b0);
    send_px(1'b0, 1'b0);
    send_px(1'b0, 1'b1);
    check_eq("eol_err_sync", {31'd0, err_sync}, 32'd1);
    s0 = shift_cnt;
    for (int i = 0; i < 3; i++) send_px(1'b0, i == 2);
    repeat (4) @(posedge clk);
    check_eq("idle_drop_shifts", 32'(shift_cnt - s0), 32'd0);
    check_eq("eol_q_empty", 32'(exp_q.size()), 32'd0);
    clean_frame("after_eol", 0);
    check_eq("err_sticky", {31'd0, err_sync}, 32'd1);
`ifdef MEDF_FRAME_CNT_EN
    check_eq("frame_cnt_3", 32'(frame_cnt), 32'd3);
`endif

    // Start-of-frame in the middle of row 1
    do_reset();
    check_eq("rst_clears_err", {31'd0, err_sync}, 32'd0);
    for (int c = 0; c < IMG_W; c++) send_px(c == 0, c == IMG_W - 1);
    send_px(1'b0, 1'b0);
    check_eq("sof_pre_q", 32'(exp_q.size()), 32'd0);
    push_windows(0, IMG_H - 1);
    send_px(1'b1, 1'b0);
    check_eq("sof_err_sync", {31'd0, err_sync}, 32'd1);
    send_frame(0, 1);
    wait_done("sof_done");
    check_eq("sof_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset during FLUSH
    do_reset();
    push_windows(0, IMG_H - 2);
    d0 = done_cnt;
    send_frame(0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("flush_rst_outputs",
             {18'd0, s_ready, lb_shift, lb_pad, win_valid, frame_done, err_sync, border, win_col, win_row},
             32'd0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    check_eq("flush_rst_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("flush_rst_q_empty", 32'(exp_q.size()), 32'd0);

`ifdef MEDF_FRAME_CNT_EN
    do_reset();
    check_eq("frame_cnt_rst", 32'(frame_cnt), 32'd0);
    for (int f = 0; f < 3; f++) clean_frame("cnt", 0);
    check_eq("frame_cnt_3b", 32'(frame_cnt), 32'd3);
    do_reset();
    check_eq("frame_cnt_clr", 32'(frame_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
